prio_grant_ctrl: RTL and testbench

PRIO_GRANT_CTRL -- requirements
Module: prio_grant_ctrl

---
 rtl/prio_arb_pkg.sv | 17 +
 rtl/prio_grant_ctrl_if.sv | 36 +++
 rtl/prio_rr_select.sv | 40 ++++
 rtl/prio_grant_ctrl.sv | 118 +++++++++++
 tb/tb_prio_grant_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/prio_arb_pkg.sv
// Shared types and helpers for the priority grant controller:
// FSM state encoding and the hold-counter width function.
package prio_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Bits needed to count up to max_hold inclusive, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_hold);
    int unsigned w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/prio_grant_ctrl_if.sv
// Bundle of the request/grant signals between requesters and the controller.
interface prio_grant_ctrl_if
  #(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3
  );
  import prio_arb_pkg::*;

  localparam int IW = $clog2(N);

  // Handshake: req is a level held by a requester until it no longer wants the
  // resource; the controller answers with a registered one-hot gnt plus
  // gnt_valid. The grantee ends its tenure with a one-cycle done pulse or by
  // dropping req; there is no ready, and a forced revoke is flagged by timeout.
  logic [N-1:0]           req;
  logic [N*PRIO_BITS-1:0] prio;
  logic [N-1:0]           mask;
  logic                   done;
  logic [N-1:0]           gnt;
  logic                   gnt_valid;
  logic [IW-1:0]          gnt_sel;
  logic [PRIO_BITS-1:0]   gnt_prio;
  logic                   timeout;
  state_e                 state;

  modport master (
    output req, prio, mask, done,
    input  gnt, gnt_valid, gnt_sel, gnt_prio, timeout, state
  );

  modport slave (
    input  req, prio, mask, done,
    output gnt, gnt_valid, gnt_sel, gnt_prio, timeout, state
  );

endinterface

// File: rtl/prio_rr_select.sv
// Combinational selector: lowest numeric priority among eligible requesters,
// ties resolved by the first index at or after rr_ptr_i (wrapping).
module prio_rr_select
  import prio_arb_pkg::*;
  #(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3,
    localparam int IW       = $clog2(N)
  ) (
    input  logic [N-1:0]           elig_i,
    input  logic [N*PRIO_BITS-1:0] prio_i,
    input  logic [IW-1:0]          rr_ptr_i,
    output logic                   found_o,
    output logic [IW-1:0]          idx_o,
    output logic [PRIO_BITS-1:0]   prio_o
  );

  logic [IW-1:0]        cand;
  logic [PRIO_BITS-1:0] cand_prio;

  // Walk in rotation order from rr_ptr_i; a strict less-than keeps the
  // earliest candidate on equal priority.
  always_comb begin
    found_o   = 1'b0;
    idx_o     = '0;
    prio_o    = '0;
    cand      = '0;
    cand_prio = '0;
    for (int o = 0; o < N; o++) begin
      cand      = rr_ptr_i + IW'(o);
      cand_prio = prio_i[int'(cand)*PRIO_BITS +: PRIO_BITS];
      if (elig_i[cand] && (!found_o || (cand_prio < prio_o))) begin
        found_o = 1'b1;
        idx_o   = cand;
        prio_o  = cand_prio;
      end
    end
  end

endmodule

// File: rtl/prio_grant_ctrl.sv
// Non-preemptive priority arbiter with round-robin tie-break, registered
// one-hot grant, release on done/req drop/mask, and a hold-time limit.
module prio_grant_ctrl
  import prio_arb_pkg::*;
  #(
    parameter int N         = 8,
    parameter int PRIO_BITS = 3,
    parameter int MAX_HOLD  = 255,
    localparam int IW       = $clog2(N)
  ) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N-1:0]           req_i,
    input  logic [N*PRIO_BITS-1:0] prio_i,
    input  logic [N-1:0]           mask_i,
    input  logic                   done_i,
    output logic [N-1:0]           gnt_o,
    output logic                   gnt_valid_o,
    output logic [IW-1:0]          gnt_sel_o,
    output logic [PRIO_BITS-1:0]   gnt_prio_o,
    output logic                   timeout_o,
    output state_e                 dbg_state_o
  );

  localparam int CW = int'(cnt_width(MAX_HOLD));

  state_e               state_q, state_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic [IW-1:0]        gnt_sel_q, gnt_sel_d;
  logic [PRIO_BITS-1:0] gnt_prio_q, gnt_prio_d;
  logic                 timeout_q, timeout_d;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]        hold_cnt_q, hold_cnt_d;

  logic                 sel_found;
  logic [IW-1:0]        sel_idx;
  logic [PRIO_BITS-1:0] sel_prio;
  logic                 early_rel;
  logic                 hold_hit;

  prio_rr_select #(
    .N         (N),
    .PRIO_BITS (PRIO_BITS)
  ) u_select (
    .elig_i   (req_i & mask_i),
    .prio_i   (prio_i),
    .rr_ptr_i (rr_ptr_q),
    .found_o  (sel_found),
    .idx_o    (sel_idx),
    .prio_o   (sel_prio)
  );

  // A voluntary release always wins over the hold limit, so no timeout then.
  assign early_rel = done_i | ~req_i[gnt_sel_q] | ~mask_i[gnt_sel_q];
  assign hold_hit  = (MAX_HOLD != 0) && (hold_cnt_q == CW'(MAX_HOLD));

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_sel_d  = gnt_sel_q;
    gnt_prio_d = gnt_prio_q;
    timeout_d  = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          state_d    = BUSY;
          gnt_d      = N'(1) << sel_idx;
          gnt_sel_d  = sel_idx;
          gnt_prio_d = sel_prio;
          rr_ptr_d   = sel_idx + IW'(1);
          hold_cnt_d = CW'(1);
        end
      end
      BUSY: begin
        if (early_rel || hold_hit) begin
          state_d    = IDLE;
          gnt_d      = '0;
          gnt_sel_d  = '0;
          gnt_prio_d = '0;
          hold_cnt_d = '0;
          timeout_d  = hold_hit & ~early_rel;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_sel_q  <= '0;
      gnt_prio_q <= '0;
      timeout_q  <= 1'b0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_sel_q  <= gnt_sel_d;
      gnt_prio_q <= gnt_prio_d;
      timeout_q  <= timeout_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = (state_q == BUSY);
  assign gnt_sel_o   = gnt_sel_q;
  assign gnt_prio_o  = gnt_prio_q;
  assign timeout_o   = timeout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prio_grant_ctrl.sv
// Directed bench for prio_grant_ctrl (N=8, PRIO_BITS=3, MAX_HOLD=4) with an
// expected-value queue checked one step after each stimulus change.
module tb_prio_grant_ctrl;
  import prio_arb_pkg::*;

  localparam int N  = 8;
  localparam int PB = 3;
  localparam int MH = 4;
  localparam int W  = 17;
  localparam logic [W-1:0] ZERO = '0;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prio_grant_ctrl_if #(.N(N), .PRIO_BITS(PB)) bus ();

  prio_grant_ctrl #(
    .N         (N),
    .PRIO_BITS (PB),
    .MAX_HOLD  (MH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (bus.req),
    .prio_i      (bus.prio),
    .mask_i      (bus.mask),
    .done_i      (bus.done),
    .gnt_o       (bus.gnt),
    .gnt_valid_o (bus.gnt_valid),
    .gnt_sel_o   (bus.gnt_sel),
    .gnt_prio_o  (bus.gnt_prio),
    .timeout_o   (bus.timeout),
    .dbg_state_o (bus.state)
  );

  // Scoreboard: {busy, gnt_valid, gnt[7:0], gnt_sel[2:0], gnt_prio[2:0], timeout}
  logic [W-1:0] exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [W-1:0] ev(input logic v, input logic [7:0] g,
                                      input logic [2:0] s, input logic [2:0] p,
                                      input logic t);
    return {v, v, g, s, p, t};
  endfunction

  function automatic logic [W-1:0] observed();
    return {bus.state == BUSY, bus.gnt_valid, bus.gnt, bus.gnt_sel,
            bus.gnt_prio, bus.timeout};
  endfunction

  task automatic compare(input string tag);
    logic [W-1:0] exp_v;
    logic [W-1:0] obs_v;
    exp_v = exp_q.pop_front();
    obs_v = observed();
    vectors++;
    assert (obs_v === exp_v) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs_v, exp_v);
    end
  endtask

  // Driver tasks
  task automatic cyc(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic check_now(input string tag, input logic [W-1:0] e);
    exp_q.push_back(e);
    compare(tag);
  endtask

  task automatic set_prio(input int k, input logic [PB-1:0] p);
    bus.prio[k*PB +: PB] = p;
  endtask

  initial begin
    bus.req  = '0;
    bus.prio = '1;
    bus.mask = '1;
    bus.done = 1'b0;
    #2;
    check_now("reset_state", ZERO);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Round-robin among equal priorities, done held high
    set_prio(1, 3'd2);
    set_prio(3, 3'd2);
    set_prio(6, 3'd2);
    bus.req  = 8'h4A;
    bus.done = 1'b1;
    cyc("rr_g1",   ev(1'b1, 8'h02, 3'd1, 3'd2, 1'b0));
    cyc("rr_gap1", ZERO);
    cyc("rr_g3",   ev(1'b1, 8'h08, 3'd3, 3'd2, 1'b0));
    cyc("rr_gap2", ZERO);
    cyc("rr_g6",   ev(1'b1, 8'h40, 3'd6, 3'd2, 1'b0));
    cyc("rr_gap3", ZERO);
    cyc("rr_g1b",  ev(1'b1, 8'h02, 3'd1, 3'd2, 1'b0));
    bus.req  = '0;
    bus.done = 1'b0;
    cyc("rr_drop", ZERO);

    // Lowest priority value wins; prio changes during BUSY ignored
    bus.prio = '1;
    set_prio(2, 3'd5);
    set_prio(5, 3'd1);
    bus.req = 8'h24;
    cyc("p_grant", ev(1'b1, 8'h20, 3'd5, 3'd1, 1'b0));
    set_prio(5, 3'd3);
    cyc("p_hold",  ev(1'b1, 8'h20, 3'd5, 3'd1, 1'b0));
    bus.done = 1'b1;
    cyc("p_done",  ZERO);
    bus.done = 1'b0;
    bus.req  = '0;
    cyc("p_idle",  ZERO);

    // Hold limit: revoke after four BUSY cycles, then release coinciding with limit
    bus.prio = '1;
    set_prio(0, 3'd4);
    bus.req = 8'h01;
    cyc("to_g",       ev(1'b1, 8'h01, 3'd0, 3'd4, 1'b0));
    cyc("to_b2",      ev(1'b1, 8'h01, 3'd0, 3'd4, 1'b0));
    cyc("to_b3",      ev(1'b1, 8'h01, 3'd0, 3'd4, 1'b0));
    cyc("to_b4",      ev(1'b1, 8'h01, 3'd0, 3'd4, 1'b0));
    cyc("to_revoke",  ev(1'b0, 8'h00, 3'd0, 3'd0, 1'b1));
    cyc("to_regrant", ev(1'b1, 8'h01, 3'd0, 3'd4, 1'b0));
    cyc("to_c2",      ev(1'b1, 8'h01, 3'd0, 3'd4, 1'b0));
    cyc("to_c3",      ev(1'b1, 8'h01, 3'd0, 3'd4, 1'b0));
    cyc("to_c4",      ev(1'b1, 8'h01, 3'd0, 3'd4, 1'b0));
    bus.done = 1'b1;
    cyc("to_done_at_max", ZERO);
    bus.done = 1'b0;
    cyc("to_regrant2", ev(1'b1, 8'h01, 3'd0, 3'd4, 1'b0));
    bus.req = '0;
    cyc("to_drop", ZERO);

    // Mask release, no preemption, masked requester stays idle
    bus.prio = '1;
    set_prio(2, 3'd3);
    bus.req = 8'h04;
    cyc("m_g2", ev(1'b1, 8'h04, 3'd2, 3'd3, 1'b0));
    set_prio(4, 3'd0);
    bus.req = 8'h14;
    cyc("m_nopreempt", ev(1'b1, 8'h04, 3'd2, 3'd3, 1'b0));
    bus.mask = 8'hFB;
    cyc("m_mask_drop", ZERO);
    cyc("m_g4", ev(1'b1, 8'h10, 3'd4, 3'd0, 1'b0));
    bus.req = 8'h04;
    cyc("m_rel4", ZERO);
    cyc("m_masked_idle", ZERO);
    bus.mask = '1;
    bus.req  = '0;

    // Asynchronous reset mid-grant
    bus.prio = '1;
    set_prio(2, 3'd3);
    bus.req = 8'h04;
    cyc("r_g2", ev(1'b1, 8'h04, 3'd2, 3'd3, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    check_now("r_async_clear", ZERO);
    bus.req = 8'h80;
    set_prio(7, 3'd0);
    cyc("r_held", ZERO);
    rst_n = 1'b1;
    cyc("r_first", ev(1'b1, 8'h80, 3'd7, 3'd0, 1'b0));
    bus.done = 1'b1;
    cyc("r_done", ZERO);
    bus.done = 1'b0;
    set_prio(0, 3'd0);
    bus.req = 8'h81;
    cyc("r_rr_wrap", ev(1'b1, 8'h01, 3'd0, 3'd0, 1'b0));
    bus.done = 1'b1;
    cyc("r_end", ZERO);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
